// File: rtl/hangman_game_ctrl_pkg.sv
// Shared constants and helpers for the hangman game controller: state codes,
// draw kinds, keyboard codes and letter qualification.
package hangman_pkg;

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_LOAD_KEY   = 4'd1;
   localparam logic [3:0] S_LOAD_DRAW  = 4'd2;
   localparam logic [3:0] S_LOAD_REL   = 4'd3;
   localparam logic [3:0] S_GUESS_KEY  = 4'd4;
   localparam logic [3:0] S_GUESS_REL  = 4'd5;
   localparam logic [3:0] S_CHECK      = 4'd6;
   localparam logic [3:0] S_CHECK_DRAW = 4'd7;
   localparam logic [3:0] S_VICTORY    = 4'd8;
   localparam logic [3:0] S_DEATH      = 4'd9;

   localparam logic [1:0] DK_BLANK  = 2'd0;
   localparam logic [1:0] DK_LETTER = 2'd1;
   localparam logic [1:0] DK_PART   = 2'd2;
   localparam logic [1:0] DK_END    = 2'd3;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_ENTER = 8'h0A;

   typedef logic [25:0] letter_set_t;

   function automatic logic is_letter(logic [7:0] k);
      return ((k >= 8'h41) && (k <= 8'h5A)) || ((k >= 8'h61) && (k <= 8'h7A));
   endfunction

   function automatic logic [7:0] to_upper(logic [7:0] k);
      return ((k >= 8'h61) && (k <= 8'h7A)) ? (k - 8'h20) : k;
   endfunction

   // Position of an uppercase letter in the 26-entry guessed set.
   function automatic logic [4:0] letter_idx(logic [7:0] u);
      return 5'(u - 8'h41);
   endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// Keyboard/renderer-facing signal bundle of the hangman controller.
// The controller takes the slave side; keyboard decoder and renderer the master side.
interface hangman_game_ctrl_if #(
   parameter int MAX_LEN = 10,
   parameter int LW      = $clog2(MAX_LEN + 1)
);

   logic [7:0]         key;
   logic               start;
   logic               draw_done;
   logic               draw_req;
   logic [1:0]         draw_kind;
   logic [LW-1:0]      draw_index;
   logic [7:0]         draw_char;
   logic [LW-1:0]      word_len;
   logic [MAX_LEN-1:0] revealed;
   logic [3:0]         wrong_count;
   logic               won;
   logic               lost;
   logic               busy;

   modport master (
      output key, start, draw_done,
      input  draw_req, draw_kind, draw_index, draw_char,
      input  word_len, revealed, wrong_count, won, lost, busy
   );

   modport slave (
      input  key, start, draw_done,
      output draw_req, draw_kind, draw_index, draw_char,
      output word_len, revealed, wrong_count, won, lost, busy
   );

endinterface

// File: rtl/hangman_game_ctrl_letter_match.sv
// Combinational compare of a guessed letter against every slot of the stored word.
module letter_match #(
   parameter int MAX_LEN = 10
) (
   input  logic [MAX_LEN-1:0][7:0] word_i,
   input  logic [7:0]              guess_i,
   output logic [MAX_LEN-1:0]      match_o
);

   always_comb begin
      match_o = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         match_o[i] = (word_i[i] == guess_i);
      end
   end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: loads a secret word, scores guesses and sequences
// one draw request at a time towards the VGA renderer.
module hangman_game_ctrl #(
   parameter int MAX_LEN   = 10,
   parameter int MAX_WRONG = 6,
   parameter int LW        = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   hangman_game_ctrl_if.slave bus
);

   import hangman_pkg::*;

   logic [3:0]               state_q, state_d;
   logic [MAX_LEN-1:0][7:0]  word_q, word_d;
   logic [LW-1:0]            len_q, len_d;
   logic [MAX_LEN-1:0]       rev_q, rev_d;
   logic [MAX_LEN-1:0]       pend_q, pend_d;
   logic [3:0]               wrong_q, wrong_d;
   letter_set_t              guessed_q, guessed_d;
   logic [7:0]               guess_q, guess_d;
   logic                     enter_q, enter_d;
   logic                     miss_q, miss_d;
   logic                     end_done_q, end_done_d;

   logic [MAX_LEN-1:0]       match;
   logic [MAX_LEN-1:0]       valid;
   logic [MAX_LEN-1:0]       hit;
   logic [MAX_LEN-1:0]       pend_low;
   logic [LW-1:0]            pidx;
   logic [7:0]               pchar;
   logic [7:0]               key_u;
   logic                     key_letter;
   logic                     all_revealed;
   logic                     draw_req;
   logic [1:0]               draw_kind;
   logic [LW-1:0]            draw_index;
   logic [7:0]               draw_char;
   logic                     done;

   letter_match #(.MAX_LEN(MAX_LEN)) u_match (
      .word_i  (word_q),
      .guess_i (guess_q),
      .match_o (match)
   );

   assign key_u        = to_upper(bus.key);
   assign key_letter   = is_letter(bus.key);
   assign hit          = match & valid;
   assign all_revealed = ((rev_q & valid) == valid);
   assign pend_low     = pend_q & (~pend_q + 1'b1);
   assign done         = bus.draw_done & draw_req;

   // Slot-valid mask and lowest pending slot (priority encoder).
   always_comb begin
      valid = '0;
      pidx  = '0;
      pchar = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         valid[i] = (LW'(i) < len_q);
      end
      for (int i = MAX_LEN - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            pidx  = LW'(i);
            pchar = word_q[i];
         end
      end
   end

   // Draw request is a pure function of state so a reset drops it immediately.
   always_comb begin
      draw_req   = 1'b0;
      draw_kind  = DK_BLANK;
      draw_index = '0;
      draw_char  = '0;
      case (state_q)
         S_LOAD_DRAW: begin
            draw_req   = 1'b1;
            draw_kind  = DK_BLANK;
            draw_index = len_q - 1'b1;
         end
         S_CHECK_DRAW: begin
            if (|pend_q) begin
               draw_req   = 1'b1;
               draw_kind  = DK_LETTER;
               draw_index = pidx;
               draw_char  = pchar;
            end else if (miss_q) begin
               draw_req   = 1'b1;
               draw_kind  = DK_PART;
               draw_index = LW'(wrong_q);
            end
         end
         S_VICTORY, S_DEATH: begin
            if (!end_done_q) begin
               draw_req  = 1'b1;
               draw_kind = DK_END;
               draw_char = (state_q == S_VICTORY) ? 8'h57 : 8'h4C;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      len_d      = len_q;
      rev_d      = rev_q;
      pend_d     = pend_q;
      wrong_d    = wrong_q;
      guessed_d  = guessed_q;
      guess_d    = guess_q;
      enter_d    = enter_q;
      miss_d     = miss_q;
      end_done_d = end_done_q;
      case (state_q)
         S_IDLE, S_VICTORY, S_DEATH: begin
            if ((state_q != S_IDLE) && done) end_done_d = 1'b1;
            if (bus.start) begin
               word_d     = '0;
               len_d      = '0;
               rev_d      = '0;
               pend_d     = '0;
               wrong_d    = '0;
               guessed_d  = '0;
               enter_d    = 1'b0;
               miss_d     = 1'b0;
               end_done_d = 1'b0;
               state_d    = S_LOAD_KEY;
            end
         end
         S_LOAD_KEY: begin
            if (key_letter) begin
               for (int i = 0; i < MAX_LEN; i++) begin
                  if (len_q == LW'(i)) word_d[i] = key_u;
               end
               len_d   = len_q + 1'b1;
               state_d = S_LOAD_DRAW;
            end else if ((bus.key == KEY_ENTER) && (len_q != '0)) begin
               enter_d = 1'b1;
               state_d = S_LOAD_REL;
            end
         end
         S_LOAD_DRAW: begin
            if (done) state_d = S_LOAD_REL;
         end
         S_LOAD_REL: begin
            if (bus.key == KEY_NONE) begin
               if (enter_q || (len_q == LW'(MAX_LEN))) begin
                  enter_d = 1'b0;
                  state_d = S_GUESS_KEY;
               end else begin
                  state_d = S_LOAD_KEY;
               end
            end
         end
         S_GUESS_KEY: begin
            if (key_letter) begin
               guess_d = key_u;
               state_d = S_GUESS_REL;
            end
         end
         S_GUESS_REL: begin
            if (bus.key == KEY_NONE) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (guessed_q[letter_idx(guess_q)]) begin
               state_d = S_GUESS_KEY;
            end else begin
               guessed_d[letter_idx(guess_q)] = 1'b1;
               if (|hit) begin
                  pend_d = hit & ~rev_q;
                  rev_d  = rev_q | hit;
                  miss_d = 1'b0;
               end else begin
                  if (wrong_q < 4'(MAX_WRONG)) wrong_d = wrong_q + 1'b1;
                  miss_d = 1'b1;
               end
               state_d = S_CHECK_DRAW;
            end
         end
         S_CHECK_DRAW: begin
            if (|pend_q) begin
               if (done) pend_d = pend_q ^ pend_low;
            end else if (miss_q) begin
               if (done) miss_d = 1'b0;
            end else begin
               // Victory takes precedence over death.
               end_done_d = 1'b0;
               if (all_revealed)                   state_d = S_VICTORY;
               else if (wrong_q >= 4'(MAX_WRONG))  state_d = S_DEATH;
               else                                state_d = S_GUESS_KEY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         len_q      <= '0;
         rev_q      <= '0;
         pend_q     <= '0;
         wrong_q    <= '0;
         guessed_q  <= '0;
         guess_q    <= '0;
         enter_q    <= 1'b0;
         miss_q     <= 1'b0;
         end_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         len_q      <= len_d;
         rev_q      <= rev_d;
         pend_q     <= pend_d;
         wrong_q    <= wrong_d;
         guessed_q  <= guessed_d;
         guess_q    <= guess_d;
         enter_q    <= enter_d;
         miss_q     <= miss_d;
         end_done_q <= end_done_d;
      end
   end

   assign bus.draw_req    = draw_req;
   assign bus.draw_kind   = draw_kind;
   assign bus.draw_index  = draw_index;
   assign bus.draw_char   = draw_char;
   assign bus.word_len    = len_q;
   assign bus.revealed    = rev_q;
   assign bus.wrong_count = wrong_q;
   assign bus.won         = (state_q == S_VICTORY);
   assign bus.lost        = (state_q == S_DEATH);
   assign bus.busy        = (state_q != S_IDLE) && (state_q != S_VICTORY) && (state_q != S_DEATH);

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Directed bench for hangman_game_ctrl: a default-sized instance and a
// MAX_LEN=2 / MAX_WRONG=2 instance driven through a shared row table.
module tb_hangman_game_ctrl;

   logic       clk;
   logic       rst;
   logic       sel;
   logic       auto_ack;
   logic [7:0] key_r;
   logic       start_r;
   logic       done_r;

   hangman_game_ctrl_if #(.MAX_LEN(10)) ifa ();
   hangman_game_ctrl_if #(.MAX_LEN(2))  ifb ();

   hangman_game_ctrl #(.MAX_LEN(10), .MAX_WRONG(6)) dut_a (.clock(clk), .reset(rst), .bus(ifa));
   hangman_game_ctrl #(.MAX_LEN(2),  .MAX_WRONG(2)) dut_b (.clock(clk), .reset(rst), .bus(ifb));

   assign ifa.key       = sel ? 8'h00 : key_r;
   assign ifa.start     = sel ? 1'b0  : start_r;
   assign ifa.draw_done = sel ? 1'b0  : done_r;
   assign ifb.key       = sel ? key_r   : 8'h00;
   assign ifb.start     = sel ? start_r : 1'b0;
   assign ifb.draw_done = sel ? done_r  : 1'b0;

   logic       o_req, o_won, o_lost, o_busy;
   logic [1:0] o_kind;
   logic [3:0] o_idx, o_len, o_wrong;
   logic [7:0] o_chr;
   logic [9:0] o_rev;

   always_comb begin
      o_req   = sel ? ifb.draw_req           : ifa.draw_req;
      o_kind  = sel ? ifb.draw_kind          : ifa.draw_kind;
      o_idx   = sel ? 4'(ifb.draw_index)     : ifa.draw_index;
      o_chr   = sel ? ifb.draw_char          : ifa.draw_char;
      o_len   = sel ? 4'(ifb.word_len)       : ifa.word_len;
      o_rev   = sel ? 10'(ifb.revealed)      : ifa.revealed;
      o_wrong = sel ? ifb.wrong_count        : ifa.wrong_count;
      o_won   = sel ? ifb.won                : ifa.won;
      o_lost  = sel ? ifb.lost               : ifa.lost;
      o_busy  = sel ? ifb.busy               : ifa.busy;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [13:0] dq [$];

   // Renderer model: acknowledge every request one cycle after it is seen, logging it.
   initial begin
      done_r = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (auto_ack && o_req) begin
            dq.push_back({o_kind, o_idx, o_chr});
            done_r = 1'b1;
         end else begin
            done_r = 1'b0;
         end
      end
   end

   int nchk;
   int npass;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] D(input logic [1:0] k, input logic [3:0] i, input logic [7:0] c);
      return {k, i, c};
   endfunction

   typedef struct {
      bit          sel;
      bit          st;
      logic [7:0]  key;
      int          hold;
      int          nd;
      logic [13:0] d0, d1, d2;
      logic [3:0]  len;
      logic [9:0]  rev;
      logic [3:0]  wrong;
      logic [2:0]  flags;   // {won, lost, busy}
   } row_t;

   function automatic row_t mk(input bit s, input bit st, input logic [7:0] k, input int hold,
                               input int nd, input logic [13:0] d0, input logic [13:0] d1,
                               input logic [13:0] d2, input logic [3:0] len, input logic [9:0] rev,
                               input logic [3:0] wrong, input logic [2:0] flags);
      row_t r;
      r.sel = s; r.st = st; r.key = k; r.hold = hold; r.nd = nd;
      r.d0 = d0; r.d1 = d1; r.d2 = d2;
      r.len = len; r.rev = rev; r.wrong = wrong; r.flags = flags;
      return r;
   endfunction

   row_t tbl [$];

   initial begin
      logic [13:0] N;
      logic [13:0] ex [3];
      N        = 14'h0;
      nchk     = 0;
      npass    = 0;
      sel      = 1'b0;
      auto_ack = 1'b0;
      key_r    = 8'h00;
      start_r  = 1'b0;
      rst      = 1'b1;

      // DUT A: MAX_LEN=10, MAX_WRONG=6
      tbl.push_back(mk(0,1,8'h00,  1,0,N,N,N,               0,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,8'h0A,  3,0,N,N,N,               0,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"5",    3,0,N,N,N,               0,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"c",  100,1,D(0,0,0),N,N,        1,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"A",    3,1,D(0,1,0),N,N,        2,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"t",    3,1,D(0,2,0),N,N,        3,10'b0000,0,3'b001));
      tbl.push_back(mk(0,1,8'h00,  1,0,N,N,N,               3,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,8'h0A,  3,0,N,N,N,               3,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"A",    3,1,D(1,1,"A"),N,N,      3,10'b0010,0,3'b001));
      tbl.push_back(mk(0,0,"A",    3,0,N,N,N,               3,10'b0010,0,3'b001));
      tbl.push_back(mk(0,0,"a",    3,0,N,N,N,               3,10'b0010,0,3'b001));
      tbl.push_back(mk(0,0,"z",    3,1,D(2,1,0),N,N,        3,10'b0010,1,3'b001));
      tbl.push_back(mk(0,0,"C",    3,1,D(1,0,"C"),N,N,      3,10'b0011,1,3'b001));
      tbl.push_back(mk(0,0,"T",    3,2,D(1,2,"T"),D(3,0,"W"),N, 3,10'b0111,1,3'b100));
      tbl.push_back(mk(0,1,8'h00,  1,0,N,N,N,               0,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"T",    3,1,D(0,0,0),N,N,        1,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"O",    3,1,D(0,1,0),N,N,        2,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"O",    3,1,D(0,2,0),N,N,        3,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"T",    3,1,D(0,3,0),N,N,        4,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,8'h0A,  3,0,N,N,N,               4,10'b0000,0,3'b001));
      tbl.push_back(mk(0,0,"t",    3,2,D(1,0,"T"),D(1,3,"T"),N, 4,10'b1001,0,3'b001));
      tbl.push_back(mk(0,0,"O",    3,3,D(1,1,"O"),D(1,2,"O"),D(3,0,"W"), 4,10'b1111,0,3'b100));
      // DUT B: MAX_LEN=2, MAX_WRONG=2
      tbl.push_back(mk(1,1,8'h00,  1,0,N,N,N,               0,10'b00,0,3'b001));
      tbl.push_back(mk(1,0,"A",    3,1,D(0,0,0),N,N,        1,10'b00,0,3'b001));
      tbl.push_back(mk(1,0,"B",    3,1,D(0,1,0),N,N,        2,10'b00,0,3'b001));
      tbl.push_back(mk(1,0,"C",    3,1,D(2,1,0),N,N,        2,10'b00,1,3'b001));
      tbl.push_back(mk(1,0,"Y",    3,2,D(2,2,0),D(3,0,"L"),N, 2,10'b00,2,3'b010));
      tbl.push_back(mk(1,1,8'h00,  1,0,N,N,N,               0,10'b00,0,3'b001));
      tbl.push_back(mk(1,0,"A",    3,1,D(0,0,0),N,N,        1,10'b00,0,3'b001));
      tbl.push_back(mk(1,0,"B",    3,1,D(0,1,0),N,N,        2,10'b00,0,3'b001));
      tbl.push_back(mk(1,0,"Q",    3,1,D(2,1,0),N,N,        2,10'b00,1,3'b001));
      tbl.push_back(mk(1,0,"a",    3,1,D(1,0,"A"),N,N,      2,10'b01,1,3'b001));
      tbl.push_back(mk(1,0,"B",    3,2,D(1,1,"B"),D(3,0,"W"),N, 2,10'b11,1,3'b100));

      // Reset state
      tick();
      chk("rst_req",   32'(o_req),   32'd0);
      chk("rst_len",   32'(o_len),   32'd0);
      chk("rst_flags", 32'({o_won, o_lost, o_busy}), 32'd0);
      chk("rst_b_busy", 32'(ifb.busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Reset while a blank-slot draw is outstanding
      start_r = 1'b1;
      tick();
      start_r = 1'b0;
      key_r   = "Q";
      tick();
      chk("middraw_req", 32'(o_req),  32'd1);
      chk("middraw_len", 32'(o_len),  32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_req",  32'(o_req),   32'd0);
      chk("rst_async_len",  32'(o_len),   32'd0);
      chk("rst_async_rev",  32'(o_rev),   32'd0);
      chk("rst_async_wr",   32'(o_wrong), 32'd0);
      chk("rst_async_busy", 32'(o_busy),  32'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      key_r = 8'h00;
      tick();
      chk("post_rst_busy", 32'(o_busy), 32'd0);
      auto_ack = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         sel = tbl[r].sel;
         tick();
         dq.delete();
         if (tbl[r].st) begin
            start_r = 1'b1;
            tick();
            start_r = 1'b0;
         end else begin
            key_r = tbl[r].key;
            repeat (tbl[r].hold) tick();
            key_r = 8'h00;
         end
         repeat (15) tick();
         ex[0] = tbl[r].d0;
         ex[1] = tbl[r].d1;
         ex[2] = tbl[r].d2;
         chk($sformatf("row%0d_ndraw", r), 32'(dq.size()), 32'(tbl[r].nd));
         for (int j = 0; j < tbl[r].nd; j++) begin
            if (j < dq.size())
               chk($sformatf("row%0d_draw%0d", r, j), 32'(dq[j]), 32'(ex[j]));
         end
         chk($sformatf("row%0d_len", r),   32'(o_len),   32'(tbl[r].len));
         chk($sformatf("row%0d_rev", r),   32'(o_rev),   32'(tbl[r].rev));
         chk($sformatf("row%0d_wrong", r), 32'(o_wrong), 32'(tbl[r].wrong));
         chk($sformatf("row%0d_flags", r), 32'({o_won, o_lost, o_busy}), 32'(tbl[r].flags));
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/hangman_game_ctrl.md
Name: hangman_game_ctrl

Overview:
- Parametrised Hangman game controller: loads a secret word from keyboard ASCII codes, accepts guesses, tracks revealed positions and wrong-guess count, and decides victory or death.
- Sits between the keyboard decoder and the VGA drawing engine.
- Issues one draw request at a time over a req/done handshake.
- Successor to the fixed-size game FSM: configurable word length and life count, a guessed-letter set, and multi-slot reveal sequencing.

Parameters:
MAX_LEN, 10, maximum secret-word length (1..16)
MAX_WRONG, 6, wrong guesses allowed before death (1..15)
LW, $clog2(MAX_LEN+1), width of length/index fields

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
key  in  8  ASCII from keyboard decoder; 8'h00 = no key held
start  in  1  one-cycle pulse; begins word load from IDLE/VICTORY/DEATH
draw_done  in  1  one-cycle pulse from renderer; completes current draw
draw_req  out  1  draw request, held until draw_done
draw_kind  out  2  0=blank slot, 1=revealed letter, 2=gallows part, 3=end screen
draw_index  out  LW  slot index (kind 0/1), part number 1..MAX_WRONG (kind 2), 0 otherwise
draw_char  out  8  uppercase ASCII (kind 1), 'W'/'L' (kind 3), 0 otherwise
word_len  out  LW  letters loaded
revealed  out  MAX_LEN  bit i set = slot i revealed
wrong_count  out  4  wrong guesses so far
won  out  1  high in VICTORY
lost  out  1  high in DEATH
busy  out  1  high in every state except IDLE, VICTORY, DEATH

Behaviour:
- Reset (async, active-high): state IDLE; every output 0; word store, guessed set (26 bits) and all counters cleared.
- Key qualification:
  - Letter = 'A'..'Z' or 'a'..'z'; lowercase folded to uppercase before storage/compare.
  - A key is accepted on the first cycle it is non-zero in a *_KEY state; the FSM then waits in the matching *_REL state until key==8'h00.
  - A held key is never accepted twice.
  - Non-letters other than 8'h0A are ignored: stay in the *_KEY state.
- States:
  - IDLE: start -> LOAD_KEY; clear word_len, revealed, wrong_count, guessed set.
  - LOAD_KEY:
    - Letter: store at slot word_len, word_len++, -> LOAD_DRAW.
    - 8'h0A with word_len>0 -> LOAD_REL (flag enter).
    - 8'h0A with word_len==0 is ignored.
  - LOAD_DRAW: draw_req=1, kind 0, index=word_len-1; on draw_done -> LOAD_REL.
  - LOAD_REL: on key==0:
    - Enter flagged or word_len==MAX_LEN -> GUESS_KEY.
    - Otherwise -> LOAD_KEY.
  - GUESS_KEY: letter -> GUESS_REL with guess latched.
  - GUESS_REL: on key==0 -> CHECK.
  - CHECK (1 cycle):
    - If the letter is already in the guessed set -> GUESS_KEY, no change.
    - Otherwise mark it guessed and compute hit = match & slot_valid, where slot_valid[i] = (i<word_len).
    - Any hit: pending = hit & ~revealed; revealed |= hit.
    - No hit: wrong_count++.
    - -> CHECK_DRAW.
  - CHECK_DRAW: one draw per set bit of pending, lowest index first.
    - kind 1, char = word[idx]; on draw_done clear that bit.
    - On a miss: one kind-2 draw with index = wrong_count.
    - When finished: all valid slots revealed -> VICTORY; else wrong_count==MAX_WRONG -> DEATH; else -> GUESS_KEY.
  - VICTORY / DEATH:
    - One kind-3 draw ('W' / 'L'); then idle with won/lost held.
    - start -> LOAD_KEY with a full clear, same as IDLE.
- Draw handshake:
  - draw_req rises in the first cycle of a draw state; kind/index/char are stable while draw_req=1.
  - draw_done without draw_req is ignored.
  - draw_done in the same cycle draw_req rises completes that draw.
- start is ignored while busy=1.
- Reset mid-draw drops draw_req asynchronously.
- No partial state survives reset.
- Victory is checked before death. A winning reveal on the last life yields VICTORY, and no gallows part is drawn because a hit never increments wrong_count.
- wrong_count saturates at MAX_WRONG.

Decomposition:
- Package hangman_pkg: state encoding, draw_kind constants (DK_BLANK, DK_LETTER, DK_PART, DK_END), ASCII constants (KEY_NONE=8'h00, KEY_ENTER=8'h0A).
- Sub-module letter_match: combinational, parametrised by MAX_LEN. Takes the word array and guess; outputs the MAX_LEN match vector.
- Pending-bit selection uses a priority encoder inside the controller.

Test Plan:
- Reset mid-LOAD_DRAW -> draw_req, word_len, revealed, wrong_count all 0 immediately; state IDLE.
- start; keys "c","A","t" each held 3 cycles then 0; then 0x0A:
  - -> three kind-0 draws at index 0,1,2.
  - -> word_len=3, busy=1, in GUESS_KEY.
- Word "CAT"; guess 'A':
  - -> one kind-1 draw, index 1, char 'A'.
  - -> revealed=3'b010, wrong_count=0.
  - Guessing 'A' again produces no draw and no change.
- Word "TOOT"; guess 'T', then 'O':
  - -> draws at index 0,3 then 1,2 in that order.
  - -> revealed=4'b1111, then a kind-3 'W' draw, won=1.
- MAX_WRONG=2, word "AB"; guesses 'X','Y':
  - -> kind-2 draws with index 1 then 2.
  - -> kind-3 'L', lost=1; then start -> word_len=0, lost=0.
- Key '5' and 0x0A with empty word in LOAD_KEY -> ignored. Key held 100 cycles -> exactly one letter stored. MAX_LEN=2 with keys "ABC" -> auto-enter after "AB"; 'C' treated as a guess.
